timer_countdown: RTL and testbench
==================================

TIMER_COUNTDOWN -- requirements
Module: timer_countdown

Interface
REQ-001 Parameter: SEC_TENS_MAX, 5, largest legal seconds-tens digit; also the reload value on a seconds-tens borrow.
REQ-002 clock  in  1  single clock; all state changes on the rising edge.
REQ-003 clear  in  1  reset, synchronous, active-high.
REQ-004 tick  in  1  one-cycle strobe, one per elapsed second.
REQ-005 load  in  1  one-cycle strobe; capture digits_in.
REQ-006 digits_in  in  16  BCD digits {min_tens[15:12], min_units[11:8], sec_tens[7:4], sec_units[3:0]}.
REQ-007 start  in  1  one-cycle strobe; begin or resume countdown.
REQ-008 stop  in  1  one-cycle strobe; pause countdown.
REQ-009 min_tens, min_units, sec_tens, sec_units  out  4 each  current remaining time, BCD, registered.
REQ-010 running  out  1  high while in state RUN.
REQ-011 done  out  1  one-cycle pulse when the countdown reaches 00:00.
REQ-012 zero  out  1  high when all four digits are 0.

Function
REQ-013 FSM states: IDLE, PAUSE, RUN, DONE.
REQ-014 load is legal only when all of the following hold:
- state is IDLE or PAUSE;
- every digit is 9 or less;
- sec_tens is SEC_TENS_MAX or less.
REQ-015 Legal load with a nonzero value: digits captured on the same edge; state becomes PAUSE.
REQ-016 Legal load with value 0000: digits captured; state becomes IDLE.
REQ-017 Illegal load: digits and state unchanged; no error output.
REQ-018 start in PAUSE with nonzero time: state becomes RUN.
REQ-019 start in any other state, or with zero time: ignored.
REQ-020 stop in RUN: state becomes PAUSE; digits hold.
REQ-021 stop and start in the same cycle: stop wins.
REQ-022 tick in RUN without stop: time decrements by 1 s on that edge.
REQ-023 tick is ignored in IDLE, PAUSE and DONE.
REQ-024 tick and stop in the same cycle: no decrement; state becomes PAUSE.
REQ-025 Decrement borrow chain:
- sec_units 0 wraps to 9 and borrows from sec_tens;
- sec_tens 0 wraps to SEC_TENS_MAX and borrows from min_units;
- min_units 0 wraps to 9 and borrows from min_tens;
- min_tens decrements.
- The value never decrements below 00:00.
REQ-026 The tick that produces 00:00 moves the state to DONE on the same edge.
REQ-027 DONE lasts exactly one cycle, then returns to IDLE unconditionally; load, start and stop are ignored while in DONE.
REQ-028 done = (state == DONE), so it is high for exactly one cycle, the cycle after the final tick edge.
REQ-029 running = (state == RUN).
REQ-030 zero is derived combinationally from the registered digits.
REQ-031 load while in RUN is ignored; the countdown continues unaffected.
REQ-032 All outputs are glitch-free functions of registered state.

Reset
REQ-033 clear high at a rising edge overrides every other input:
- state becomes IDLE;
- all digits become 0;
- running = 0, done = 0, zero = 1.
REQ-034 clear mid-RUN or during DONE aborts immediately; no done pulse is produced afterward.
REQ-035 The first operation after clear is accepted on the first edge with clear low.

Verification
REQ-036 Assert clear for 2 cycles, inputs arbitrary -> digits 0000, running 0, done 0, zero 1.
REQ-037 Full countdown:
- stimulus: load 0x0105, start, then 65 ticks spaced 3 cycles apart;
- digits step 01:05, 01:04 … 01:00, 00:59 … 00:00;
- done is high for exactly one cycle after the 65th tick edge;
- state then returns to IDLE.
REQ-038 Illegal load: load 0x0170 (sec_tens 7) -> rejected; digits stay 0000, state stays IDLE. A subsequent load of 0x0130 is accepted and shows 01:30.
REQ-039 Pause and resume:
- RUN at 00:10; assert tick and stop in the same cycle -> digits 00:10, running 0;
- start, then tick -> 00:09.
REQ-040 clear mid-run: RUN at 00:30, assert clear -> 0000, IDLE; no done pulse follows.
REQ-041 Wrap and load-in-RUN:
- load 0x9959, start, one tick -> 99:58;
- load 0x0001 while in RUN -> ignored; next tick gives 99:57;
- load 0x1000, start, one tick -> 09:59.

Source files
------------

// File: rtl/timer_countdown.sv
// mm:ss BCD countdown timer with load/start/stop control and a one-cycle done pulse.
// State  | meaning
// IDLE   | no time pending (zero or freshly cleared)
// PAUSE  | nonzero time loaded or countdown halted; waiting for start
// RUN    | decrementing on each tick
// DONE   | single cycle after reaching 00:00, then back to IDLE
module timer_countdown #(
  parameter int SEC_TENS_MAX = 5
) (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_tick,
  input  logic        i_load,
  input  logic [15:0] i_digits_in,
  input  logic        i_start,
  input  logic        i_stop,
  output logic [3:0]  o_min_tens,
  output logic [3:0]  o_min_units,
  output logic [3:0]  o_sec_tens,
  output logic [3:0]  o_sec_units,
  output logic        o_running,
  output logic        o_done,
  output logic        o_zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PAUSE = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LP_ST_MAX = 4'(SEC_TENS_MAX);

  logic [1:0] r_state;
  logic [3:0] r_mt, r_mu, r_st, r_su;

  logic       w_zero;
  logic       w_load_ok;
  logic       w_load_zero;
  logic       w_dec_to_zero;
  logic [3:0] w_mt_dec, w_mu_dec, w_st_dec, w_su_dec;

  assign w_zero = (r_mt == 4'd0) && (r_mu == 4'd0) && (r_st == 4'd0) && (r_su == 4'd0);

  assign w_load_ok = ((r_state == S_IDLE) || (r_state == S_PAUSE)) &&
                     (i_digits_in[15:12] <= 4'd9) && (i_digits_in[11:8] <= 4'd9) &&
                     (i_digits_in[7:4] <= LP_ST_MAX) && (i_digits_in[7:4] <= 4'd9) &&
                     (i_digits_in[3:0] <= 4'd9);
  assign w_load_zero = (i_digits_in == 16'h0000);

  // Borrow chain; only evaluated when the current value is nonzero.
  always_comb begin
    w_mt_dec = r_mt;
    w_mu_dec = r_mu;
    w_st_dec = r_st;
    w_su_dec = r_su;
    if (r_su != 4'd0) begin
      w_su_dec = r_su - 4'd1;
    end else begin
      w_su_dec = 4'd9;
      if (r_st != 4'd0) begin
        w_st_dec = r_st - 4'd1;
      end else begin
        w_st_dec = LP_ST_MAX;
        if (r_mu != 4'd0) begin
          w_mu_dec = r_mu - 4'd1;
        end else begin
          w_mu_dec = 4'd9;
          w_mt_dec = r_mt - 4'd1;
        end
      end
    end
  end

  assign w_dec_to_zero = (r_mt == 4'd0) && (r_mu == 4'd0) && (r_st == 4'd0) && (r_su == 4'd1);

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= S_IDLE;
      r_mt    <= 4'd0;
      r_mu    <= 4'd0;
      r_st    <= 4'd0;
      r_su    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if (i_load && w_load_ok) begin
            r_mt    <= i_digits_in[15:12];
            r_mu    <= i_digits_in[11:8];
            r_st    <= i_digits_in[7:4];
            r_su    <= i_digits_in[3:0];
            r_state <= w_load_zero ? S_IDLE : S_PAUSE;
          end else if (r_state == S_PAUSE && i_start && !i_stop && !w_zero) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_state <= S_PAUSE;
          end else if (i_tick && !w_zero) begin
            r_mt <= w_mt_dec;
            r_mu <= w_mu_dec;
            r_st <= w_st_dec;
            r_su <= w_su_dec;
            if (w_dec_to_zero) begin
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_min_tens  = r_mt;
  assign o_min_units = r_mu;
  assign o_sec_tens  = r_st;
  assign o_sec_units = r_su;
  assign o_running   = (r_state == S_RUN);
  assign o_done      = (r_state == S_DONE);
  assign o_zero      = w_zero;

endmodule

// File: tb/tb_timer_countdown.sv
// Scoreboard bench: stimulus queues the expected output snapshot for every change it causes;
// the monitor pops one entry per observed output change and reports unexpected changes.
module tb_timer_countdown;

  logic        clk = 1'b0;
  logic        i_clear = 1'b0, i_tick = 1'b0, i_load = 1'b0, i_start = 1'b0, i_stop = 1'b0;
  logic [15:0] i_digits_in = 16'h0000;
  logic [3:0]  o_min_tens, o_min_units, o_sec_tens, o_sec_units;
  logic        o_running, o_done, o_zero;

  typedef logic [18:0] obs_t;
  obs_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  timer_countdown #(.SEC_TENS_MAX(5)) dut (
    .i_clock     (clk),
    .i_clear     (i_clear),
    .i_tick      (i_tick),
    .i_load      (i_load),
    .i_digits_in (i_digits_in),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .o_min_tens  (o_min_tens),
    .o_min_units (o_min_units),
    .o_sec_tens  (o_sec_tens),
    .o_sec_units (o_sec_units),
    .o_running   (o_running),
    .o_done      (o_done),
    .o_zero      (o_zero)
  );

  obs_t w_obs;
  assign w_obs = {o_min_tens, o_min_units, o_sec_tens, o_sec_units, o_running, o_done, o_zero};

  function automatic obs_t mk(input logic [15:0] d, input logic run, input logic dn, input logic zr);
    return {d, run, dn, zr};
  endfunction

  function automatic logic [15:0] bcd_of(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Monitor: any change of the observed output vector is one DUT response.
  initial begin
    obs_t prev;
    obs_t e;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (w_obs !== prev) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_change: got %h, required no change from %h", w_obs, prev);
        end else begin
          e = exp_q.pop_front();
          if (w_obs !== e) begin
            tests_failed++;
            $display("FAIL output_step: got %h, required %h (digits,run,done,zero)", w_obs, e);
          end
        end
        prev = w_obs;
      end
    end
  end

  task automatic cyc(input logic c, input logic ld, input logic st, input logic sp,
                     input logic tk, input logic [15:0] d);
    i_clear = c; i_load = ld; i_start = st; i_stop = sp; i_tick = tk; i_digits_in = d;
    @(posedge clk);
    #1;
    i_clear = 1'b0; i_load = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i_digits_in);
  endtask

  initial begin
    // Reset with arbitrary inputs on the other pins
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1));
    repeat (2) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    idle(2);

    // Full countdown from 01:05
    exp_q.push_back(mk(16'h0105, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0105);
    exp_q.push_back(mk(16'h0105, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 64; k >= 0; k--) begin
      idle(2);
      if (k > 0) begin
        exp_q.push_back(mk(bcd_of(k), 1'b1, 1'b0, 1'b0));
      end else begin
        exp_q.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b1));
        exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1));
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    end
    idle(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);   // start at zero: ignored
    idle(2);

    // Illegal loads are rejected, legal one accepted
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0170);
    idle(1);
    exp_q.push_back(mk(16'h0130, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0130);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0A00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000A);
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);   // IDLE: start ignored
    idle(2);

    // Pause and resume, stop priority
    exp_q.push_back(mk(16'h0010, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);   // tick in PAUSE ignored
    exp_q.push_back(mk(16'h0010, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(1);
    exp_q.push_back(mk(16'h0010, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    exp_q.push_back(mk(16'h0010, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(1);
    exp_q.push_back(mk(16'h0009, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    exp_q.push_back(mk(16'h0009, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(2);

    // Clear mid-run: no done pulse afterwards
    exp_q.push_back(mk(16'h0030, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030);
    exp_q.push_back(mk(16'h0030, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    idle(1);
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(4);

    // Wrap and load-in-RUN
    exp_q.push_back(mk(16'h9959, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h9959);
    exp_q.push_back(mk(16'h9959, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    exp_q.push_back(mk(16'h9958, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001);
    idle(1);
    exp_q.push_back(mk(16'h9957, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    exp_q.push_back(mk(16'h9957, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    exp_q.push_back(mk(16'h1000, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
    exp_q.push_back(mk(16'h1000, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    exp_q.push_back(mk(16'h0959, 1'b1, 1'b0, 1'b0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(4);

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_responses: got %0d still pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
